// File: rtl/bram_loader.sv
// bram_loader: framed byte stream to 16-bit BRAM write-port loader with checksum and timeout
// Ports:
//   clk, rst           - clock (also BRAM wclk), asynchronous active-high reset
//   in_valid, in_data  - byte stream from the serial receiver
//   in_ready           - loader takes the byte this cycle (transfer = in_valid && in_ready)
//   we, waddr, wdata   - BRAM write port, one-cycle we pulse per assembled word
//   busy               - frame in progress, CPU held in reset while high
//   done               - one-cycle pulse as a frame ends
//   err                - last frame failed (bad checksum or inter-byte timeout)
module bram_loader #(
    parameter logic [7:0]  START_ADDR = 8'h00,
    parameter logic [23:0] TIMEOUT    = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [7:0]  waddr,
    output logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_END} state_t;
    state_t      state;
    logic [7:0]  hi;
    logic [7:0]  sum;
    logic [7:0]  idx;
    logic [8:0]  rem;
    logic [23:0] tmr;
    logic        xfer;
    logic        waiting;
    logic        timeout;
    assign in_ready = state != S_WRITE && state != S_END;
    assign busy     = state != S_IDLE;
    assign xfer     = in_valid && in_ready;
    // the idle-cycle timer only runs while a frame is waiting for its next byte
    assign waiting  = state == S_COUNT || state == S_HI || state == S_LO || state == S_CHECK;
    assign timeout  = waiting && !xfer && tmr == TIMEOUT - 24'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            hi    <= 8'h00;
            sum   <= 8'h00;
            idx   <= 8'h00;
            rem   <= 9'h000;
            tmr   <= 24'h0;
            we    <= 1'b0;
            waddr <= START_ADDR;
            wdata <= 16'h0000;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            tmr  <= (waiting && !xfer) ? tmr + 24'd1 : 24'h0;
            if (timeout) begin
                err   <= 1'b1;
                done  <= 1'b1;
                state <= S_END;
            end else begin
                case (state)
                    S_IDLE: if (xfer && in_data == 8'hA5) begin
                        err   <= 1'b0;
                        sum   <= 8'h00;
                        idx   <= 8'h00;
                        state <= S_COUNT;
                    end
                    // a count of zero means 256 words
                    S_COUNT: if (xfer) begin
                        rem   <= {in_data == 8'h00, in_data};
                        state <= S_HI;
                    end
                    S_HI: if (xfer) begin
                        hi    <= in_data;
                        sum   <= sum + in_data;
                        state <= S_LO;
                    end
                    // the write-port registers load here so they are valid throughout WRITE
                    S_LO: if (xfer) begin
                        sum   <= sum + in_data;
                        we    <= 1'b1;
                        waddr <= START_ADDR + idx;
                        wdata <= {hi, in_data};
                        idx   <= idx + 8'd1;
                        rem   <= rem - 9'd1;
                        state <= S_WRITE;
                    end
                    S_WRITE: state <= (rem == 9'd0) ? S_CHECK : S_HI;
                    S_CHECK: if (xfer) begin
                        if (in_data != sum) err <= 1'b1;
                        done  <= 1'b1;
                        state <= S_END;
                    end
                    S_END: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bram_loader.sv
// tb_bram_loader: randomized frame stimulus checked against a frame-level scoreboard model
module tb_bram_loader;
    localparam logic [7:0]  SA = 8'h80;
    localparam int          TO = 40;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, we, busy, done, err;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    int          vectors = 0;
    int          miscompares = 0;
    int          sync_cnt = 0;
    int          seen = 0;
    logic        exp_err = 1'b0;
    logic        prev_we = 1'b0;
    logic [23:0] exp_w[$];
    logic        exp_o[$];
    logic [15:0] wbuf[256];
    logic [23:0] e;

    always #5 clk = ~clk;

    bram_loader #(.START_ADDR(SA), .TIMEOUT(24'(TO))) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] csum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(wbuf[i][15:8]) + int'(wbuf[i][7:0]);
        return 8'(s % 256);
    endfunction

    task automatic send(input logic [7:0] b, input bit sync, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_wait", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (sync) sync_cnt++;
    endtask

    task automatic frame(input int n, input bit bad, input int maxgap);
        logic [7:0] c = csum(n);
        send(8'hA5, 1, $urandom_range(0, maxgap));
        send(8'(n), 0, $urandom_range(0, maxgap));
        for (int i = 0; i < n; i++) begin
            send(wbuf[i][15:8], 0, $urandom_range(0, maxgap));
            send(wbuf[i][7:0], 0, $urandom_range(0, maxgap));
            exp_w.push_back({SA + 8'(i), wbuf[i]});
        end
        send(bad ? c + 8'd1 : c, 0, $urandom_range(0, maxgap));
        exp_o.push_back(bad);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, {31'b0, we}, 0);
        check({tag, "_waddr"}, {24'b0, waddr}, {24'b0, SA});
        check({tag, "_wdata"}, {16'b0, wdata}, 0);
        check({tag, "_busy"}, {31'b0, busy}, 0);
        check({tag, "_done"}, {31'b0, done}, 0);
        check({tag, "_err"}, {31'b0, err}, 0);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_we = 1'b0;
                    exp_err = 1'b0;
                    seen = sync_cnt;
                    continue;
                end
                if (seen != sync_cnt) begin
                    exp_err = 1'b0;
                    seen = sync_cnt;
                end
                if (we) begin
                    check("we_back_to_back", {31'b0, prev_we}, 0);
                    check("we_expected", {31'b0, exp_w.size() > 0}, 1);
                    if (exp_w.size() > 0) begin
                        e = exp_w.pop_front();
                        check("waddr", {24'b0, waddr}, {24'b0, e[23:16]});
                        check("wdata", {16'b0, wdata}, {16'b0, e[15:0]});
                    end
                end
                if (done) begin
                    check("done_expected", {31'b0, exp_o.size() > 0}, 1);
                    if (exp_o.size() > 0) exp_err = exp_o.pop_front();
                    check("done_err", {31'b0, err}, {31'b0, exp_err});
                    check("done_in_ready", {31'b0, in_ready}, 0);
                    check("done_busy", {31'b0, busy}, 1);
                end else begin
                    check("err_level", {31'b0, err}, {31'b0, exp_err});
                end
                check("idle_ready", {31'b0, in_ready | busy}, 1);
                prev_we = we;
            end
        join_none
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        // model pins against hand-computed checksums
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        check("pin_sum_good", {24'b0, csum(2)}, 32'hBE);
        frame(2, 0, 0);
        frame(2, 1, 0);
        // leading garbage is ignored in IDLE
        send(8'h00, 0, 0);
        send(8'hFF, 0, 0);
        send(8'h5A, 0, 0);
        wbuf[0] = 16'h0007;
        check("pin_sum_small", {24'b0, csum(1)}, 32'h07);
        frame(1, 0, 0);
        // count byte 0 means 256 words; addresses wrap past 0xFF
        for (int i = 0; i < 256; i++) wbuf[i] = 16'(i);
        check("pin_sum_256", {24'b0, csum(256)}, 32'h80);
        frame(256, 0, 0);
        for (int f = 0; f < 20; f++) begin
            int n = $urandom_range(1, 12);
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                logic [7:0] b = 8'($urandom);
                send(b == 8'hA5 ? 8'h00 : b, 0, $urandom_range(0, 2));
            end
            for (int i = 0; i < n; i++)
                wbuf[i] = ($urandom_range(0, 4) == 0) ? {8'hA5, 8'($urandom)} : 16'($urandom);
            frame(n, $urandom_range(0, 2) == 0, 3);
        end
        // inter-byte timeout mid-word
        send(8'hA5, 1, 1);
        send(8'h01, 0, 0);
        send(8'h12, 0, 0);
        exp_o.push_back(1'b1);
        repeat (TO - 3) @(negedge clk);
        check("timeout_not_early", exp_o.size(), 1);
        repeat (10) @(negedge clk);
        check("timeout_done_seen", exp_o.size(), 0);
        check("timeout_in_ready", {31'b0, in_ready}, 1);
        check("timeout_busy", {31'b0, busy}, 0);
        check("timeout_err_held", {31'b0, err}, 1);
        // asynchronous reset one cycle after the high byte of word 3
        for (int i = 0; i < 5; i++) wbuf[i] = 16'($urandom);
        send(8'hA5, 1, 0);
        send(8'h05, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send(wbuf[i][15:8], 0, 0);
            send(wbuf[i][7:0], 0, 0);
            exp_w.push_back({SA + 8'(i), wbuf[i]});
        end
        send(wbuf[3][15:8], 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        check("reset_writes_drained", exp_w.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) wbuf[i] = 16'($urandom);
        frame(3, 0, 1);
        repeat (6) @(negedge clk);
        check("writes_drained", exp_w.size(), 0);
        check("frames_drained", exp_o.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
